// File: rtl/acorn128_decrypt_core.sv
// Bit-serial ACORN-128 decryption: recovers plaintext bit by bit, runs the padding phase, then hands the state to tag generation.
// Optional ACORN_DEC_BITCNT_EN adds a saturating 64-bit count of accepted ciphertext bits.
module acorn128_decrypt_core #(
  parameter int PAD_STEPS    = 256,
  parameter int PAD_CA_STEPS = 192
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         empty_msg,
  input  logic [292:0] state_in,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_cbit,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_pbit,
  output logic         done,
  input  logic         ack,
`ifdef ACORN_DEC_BITCNT_EN
  output logic [63:0]  bit_count,
`endif
  output logic [292:0] state_out
);

  localparam int CW = $clog2(PAD_STEPS + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAD, DONE} state_e;

  state_e         st_q, st_d;
  logic [292:0]   s_q, s_d;
  logic [CW-1:0]  pad_q, pad_d;
  logic           last_q, last_d;
  logic           mv_q, mv_d;
  logic           mp_q, mp_d;

  logic [292:0]   t;
  logic [292:0]   s_next;
  logic           ks, f, ca, m, accept;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic ch(input logic a, input logic b, input logic c);
    return (a & b) ^ (~a & c);
  endfunction

  // Linear LFSR mixing; keystream and feedback are taken from the mixed state.
  always_comb begin
    t      = s_q;
    t[289] = s_q[289] ^ s_q[235] ^ s_q[230];
    t[230] = s_q[230] ^ s_q[196] ^ s_q[193];
    t[193] = s_q[193] ^ s_q[160] ^ s_q[154];
    t[154] = s_q[154] ^ s_q[111] ^ s_q[107];
    t[107] = s_q[107] ^ s_q[66]  ^ s_q[61];
    t[61]  = s_q[61]  ^ s_q[23]  ^ s_q[0];
  end

  assign ks     = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
  assign f      = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]);
  assign s_next = {f ^ m, t[292:1]};

  assign s_ready = (st_q == DATA) && !last_q && (!mv_q || m_ready);
  assign accept  = s_valid && s_ready;

  // Step inputs kept apart from the FSM so s_next never loops through it.
  always_comb begin
    ca = 1'b0;
    m  = 1'b0;
    case (st_q)
      DATA: begin
        ca = 1'b1;
        m  = s_cbit ^ ks;
      end
      PAD: begin
        ca = (pad_q < CW'(PAD_CA_STEPS));
        m  = (pad_q == '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    st_d   = st_q;
    s_d    = s_q;
    pad_d  = pad_q;
    last_d = last_q;
    mv_d   = mv_q;
    mp_d   = mp_q;
    if (mv_q && m_ready) mv_d = 1'b0;
    case (st_q)
      IDLE: if (start) begin
        s_d    = state_in;
        pad_d  = '0;
        last_d = 1'b0;
        st_d   = empty_msg ? PAD : DATA;
      end
      DATA: begin
        if (accept) begin
          s_d  = s_next;
          mv_d = 1'b1;
          mp_d = m;
          if (s_last) last_d = 1'b1;
        end else if (last_q && (!mv_q || m_ready)) begin
          // final plaintext bit has drained; padding may start
          st_d = PAD;
        end
      end
      PAD: begin
        s_d   = s_next;
        pad_d = pad_q + 1'b1;
        if (pad_q == CW'(PAD_STEPS - 1)) st_d = DONE;
      end
      DONE: if (ack) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      s_q    <= '0;
      pad_q  <= '0;
      last_q <= 1'b0;
      mv_q   <= 1'b0;
      mp_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      s_q    <= s_d;
      pad_q  <= pad_d;
      last_q <= last_d;
      mv_q   <= mv_d;
      mp_q   <= mp_d;
    end
  end

  assign m_valid   = mv_q;
  assign m_pbit    = mp_q;
  assign done      = (st_q == DONE);
  assign state_out = done ? s_q : '0;

`ifdef ACORN_DEC_BITCNT_EN
  logic [63:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt_q <= '0;
    else if (st_q == IDLE && start)  cnt_q <= '0;
    else if (accept && cnt_q != '1)  cnt_q <= cnt_q + 64'd1;
  end

  assign bit_count = cnt_q;
`endif

endmodule

// File: tb/tb_acorn128_decrypt_core.sv
// Scoreboard bench for acorn128_decrypt_core: an encryption-side model produces ciphertext and post-pad states.
module tb_acorn128_decrypt_core;

  localparam int PAD_STEPS = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, empty_msg = 1'b0;
  logic [292:0] state_in = '0;
  logic         s_valid = 1'b0, s_cbit = 1'b0, s_last = 1'b0;
  logic         s_ready, m_valid, m_pbit, done;
  logic         m_ready = 1'b1, ack = 1'b0;
  logic [292:0] state_out;
`ifdef ACORN_DEC_BITCNT_EN
  logic [63:0]  bit_count;
`endif

  int vec = 0;
  int errs = 0;
  logic exp_q[$];

  acorn128_decrypt_core dut (
    .clk(clk), .rst(rst), .start(start), .empty_msg(empty_msg), .state_in(state_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_cbit(s_cbit), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_pbit(m_pbit), .done(done), .ack(ack),
`ifdef ACORN_DEC_BITCNT_EN
    .bit_count(bit_count),
`endif
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  // ---------------- golden model ----------------
  function automatic logic [292:0] mix(input logic [292:0] s);
    logic [292:0] t;
    t = s;
    t[289] = s[289] ^ s[235] ^ s[230];
    t[230] = s[230] ^ s[196] ^ s[193];
    t[193] = s[193] ^ s[160] ^ s[154];
    t[154] = s[154] ^ s[111] ^ s[107];
    t[107] = s[107] ^ s[66]  ^ s[61];
    t[61]  = s[61]  ^ s[23]  ^ s[0];
    return t;
  endfunction

  function automatic logic mdl_ks(input logic [292:0] s);
    logic [292:0] t;
    t = mix(s);
    return t[12] ^ t[154] ^ ((t[235] & t[61]) ^ (t[235] & t[193]) ^ (t[61] & t[193]))
         ^ ((t[230] & t[111]) ^ (~t[230] & t[66]));
  endfunction

  function automatic logic [292:0] mdl_step(input logic [292:0] s, input logic ca, input logic m);
    logic [292:0] t;
    logic fb;
    t  = mix(s);
    fb = t[0] ^ ~t[107] ^ ((t[244] & t[23]) ^ (t[244] & t[160]) ^ (t[23] & t[160])) ^ (ca & t[196]);
    return {fb ^ m, t[292:1]};
  endfunction

  task automatic mdl_encrypt(input logic [292:0] st, input int n, input logic [63:0] pt,
                             output logic [63:0] ct, output logic [292:0] fin);
    logic [292:0] s;
    s  = st;
    ct = '0;
    for (int i = 0; i < n; i++) begin
      ct[i] = pt[i] ^ mdl_ks(s);
      s     = mdl_step(s, 1'b1, pt[i]);
    end
    for (int j = 0; j < PAD_STEPS; j++) s = mdl_step(s, j < 192, j == 0);
    fin = s;
  endtask

  // ---------------- plaintext scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      vec++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL pbit_extra: got m_pbit=%0b, no bit expected", m_pbit);
      end else begin
        logic e;
        e = exp_q.pop_front();
        if (m_pbit !== e) begin
          errs++;
          $display("FAIL pbit: got %0b, want %0b", m_pbit, e);
        end
      end
    end
  end

  // Drive one message; returns cycles from last acceptance (or start) until done.
  task automatic run_msg(input logic [292:0] st, input int n, input logic [63:0] ct,
                         input logic [63:0] pt, input int stall_at, output int cnt);
    int i, guard;
    bit stalled, bad_rdy;
    @(posedge clk); #1;
    state_in = st; empty_msg = (n == 0); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0; guard = 0; stalled = 0; bad_rdy = 0;
    while (i < n && guard < 2000) begin
      if (i == stall_at && !stalled) begin
        stalled = 1;
        m_ready = 1'b0; s_valid = 1'b1; s_cbit = ct[i]; s_last = (i == n - 1);
        repeat (5) begin
          @(negedge clk);
          vec++;
          if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_pbit !== pt[i-1]) begin
            errs++;
            $display("FAIL stall_hold: s_ready=%0b m_valid=%0b m_pbit=%0b, want 0 1 %0b",
                     s_ready, m_valid, m_pbit, pt[i-1]);
          end
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
      end
      s_valid = ($urandom_range(0, 3) != 0);
      s_cbit  = ct[i];
      s_last  = (i == n - 1);
      @(negedge clk);
      if (s_valid && s_ready) begin
        exp_q.push_back(pt[i]);
        i++;
      end
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    cnt = (n == 0) ? 0 : 1;
    while (!done && cnt < 1000) begin
      if (s_ready) bad_rdy = 1;
      @(posedge clk); cnt++; #1;
    end
    vec++;
    if (!done || guard >= 2000) begin
      errs++;
      $display("FAIL timeout: done=%0b accepted=%0d of %0d", done, i, n);
    end
    vec++;
    if (bad_rdy || exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain: s_ready after last=%0b, pending plaintext=%0d, want 0 0", bad_rdy, exp_q.size());
    end
  endtask

  task automatic do_ack();
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    vec++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL ack: done=%0b, want 0", done);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    vec++;
    if ({s_ready, m_valid, m_pbit, done} !== 4'b0 || state_out !== '0) begin
      errs++;
      $display("FAIL reset: rdy=%0b mv=%0b mp=%0b done=%0b so=%h, want all 0",
               s_ready, m_valid, m_pbit, done, state_out);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single_bit();
    logic [63:0] ct; logic [292:0] fin; int cnt;
    mdl_encrypt('0, 1, 64'h1, ct, fin);
    run_msg('0, 1, 64'h1, 64'h1, -1, cnt);
    vec++;
    if (cnt != PAD_STEPS + 2) begin
      errs++;
      $display("FAIL single_latency: %0d cycles, want %0d", cnt, PAD_STEPS + 2);
    end
    vec++;
    if (state_out !== fin) begin
      errs++;
      $display("FAIL single_state: got %h want %h", state_out, fin);
    end
    do_ack();
  endtask

  task automatic test_empty(input logic [292:0] st);
    logic [63:0] ct; logic [292:0] fin; int cnt;
    mdl_encrypt(st, 0, '0, ct, fin);
    run_msg(st, 0, '0, '0, -1, cnt);
    vec++;
    if (cnt != PAD_STEPS) begin
      errs++;
      $display("FAIL empty_latency: %0d cycles, want %0d", cnt, PAD_STEPS);
    end
    vec++;
    if (state_out !== fin) begin
      errs++;
      $display("FAIL empty_state: got %h want %h", state_out, fin);
    end
  endtask

  task automatic test_msg(input logic [292:0] st, input int n, input logic [63:0] pt, input int stall_at);
    logic [63:0] ct; logic [292:0] fin; int cnt;
    mdl_encrypt(st, n, pt, ct, fin);
    run_msg(st, n, ct, pt, stall_at, cnt);
    vec++;
    if (cnt != PAD_STEPS + 2) begin
      errs++;
      $display("FAIL msg_latency: %0d cycles, want %0d", cnt, PAD_STEPS + 2);
    end
    vec++;
    if (state_out !== fin) begin
      errs++;
      $display("FAIL msg_state: got %h want %h", state_out, fin);
    end
`ifdef ACORN_DEC_BITCNT_EN
    vec++;
    if (bit_count !== 64'(n)) begin
      errs++;
      $display("FAIL bit_count: got %0d want %0d", bit_count, n);
    end
`endif
    do_ack();
  endtask

  task automatic test_reset_mid_pad(input logic [292:0] st);
    @(posedge clk); #1 state_in = st; empty_msg = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    vec++;
    if ({s_ready, m_valid, m_pbit, done} !== 4'b0 || state_out !== '0) begin
      errs++;
      $display("FAIL mid_reset: rdy=%0b mv=%0b mp=%0b done=%0b, want all 0", s_ready, m_valid, m_pbit, done);
    end
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    test_empty(st);
`ifdef ACORN_DEC_BITCNT_EN
    vec++;
    if (bit_count !== 64'd0) begin
      errs++;
      $display("FAIL bit_count_clear: got %0d want 0", bit_count);
    end
`endif
    do_ack();
  endtask

  logic [292:0] st_a, st_b;

  initial begin
    st_a = {10{32'hA5C3_1E7B}};
    st_b = {10{32'h0F1E_2D3C}} ^ {293{1'b1}};
    test_reset();
    test_single_bit();
    test_empty('0);
    do_ack();
    test_msg(st_a, 64, 64'hDEAD_BEEF_0123_4567, -1);
    test_msg(st_b, 20, 64'h000A_5F3C, 8);
    test_msg(st_a ^ st_b, 37, 64'h1F_2E3D_4C5B, 17);
    test_reset_mid_pad(st_b);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
